// File: rtl/rs_pkg.sv
// Shared types for the multi-CDB reservation station.
// Entry layout and dispatch bundle live here so stages agree on widths.
package rs_pkg;

  localparam int TAG_W = 5;
  localparam int OP_W  = 6;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    logic            qj_busy;
    logic            qk_busy;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [XLEN-1:0] vj;
    logic [XLEN-1:0] vk;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [TAG_W-1:0] tag;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] vj;
    logic [XLEN-1:0] vk;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [TAG_W-1:0] tag;
  } rs_disp_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative allocation order of RS slots and
// grants the oldest requesting slot (one-hot).
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] = slot i was allocated before slot j
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (free[i] || free[j])
            older[i][j] <= 1'b0;
          if (alloc[j] && i != j)
            older[i][j] <= 1'b1;
          if (alloc[i])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = req;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (req[j] && older[j][i])
          grant[i] = 1'b0;
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with NUM_CDB wakeup ports, issue-time capture,
// oldest-first select and a valid/ready dispatch register.
module rs_multi_cdb
  import rs_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_qj_busy,
  input  logic                     in_qk_busy,
  input  logic [TAG_W-1:0]         in_qj,
  input  logic [TAG_W-1:0]         in_qk,
  input  logic [XLEN-1:0]          in_vj,
  input  logic [XLEN-1:0]          in_vk,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [XLEN-1:0]          out_vj,
  output logic [XLEN-1:0]          out_vk,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rs_entry_t        ent [DEPTH];
  rs_entry_t        new_ent;
  rs_disp_t         sel, disp_q;
  logic [DEPTH-1:0] vld, req, grant, alloc, free;
  logic [IW-1:0]    free_idx;
  logic             issue, load;
  logic [XLEN:0]    in_j, in_k;
  logic [XLEN:0]    wj [DEPTH];
  logic [XLEN:0]    wk [DEPTH];

  // {busy, value} after snooping every port; lowest port wins
  function automatic logic [XLEN:0] wake(
    input logic             busy,
    input logic [TAG_W-1:0] q,
    input logic [XLEN-1:0]  v
  );
    logic [XLEN:0] r;
    r = {busy, v};
    for (int p = NUM_CDB-1; p >= 0; p--)
      if (busy && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == q)
        r = {1'b0, cdb_data[p*XLEN +: XLEN]};
    return r;
  endfunction

  always_comb begin
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ent[i].valid;
      req[i] = ent[i].valid && !ent[i].qj_busy && !ent[i].qk_busy;
      wj[i]  = wake(ent[i].qj_busy, ent[i].qj, ent[i].vj);
      wk[i]  = wake(ent[i].qk_busy, ent[i].qk, ent[i].vk);
    end
    for (int i = DEPTH-1; i >= 0; i--)
      if (!vld[i])
        free_idx = IW'(i);
  end

  assign full  = &vld;
  assign issue = rdy && !flush && in_valid && !full;
  assign load  = rdy && !flush && (!out_valid || out_ready) && |req;
  assign alloc = issue ? (DEPTH'(1) << free_idx) : '0;
  assign free  = load ? grant : '0;
  assign in_j  = wake(in_qj_busy, in_qj, in_vj);
  assign in_k  = wake(in_qk_busy, in_qk, in_vk);

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = in_op;
    new_ent.qj_busy = in_j[XLEN];
    new_ent.qk_busy = in_k[XLEN];
    new_ent.qj      = in_qj;
    new_ent.qk      = in_qk;
    new_ent.vj      = in_j[XLEN-1:0];
    new_ent.vk      = in_k[XLEN-1:0];
    new_ent.imm     = in_imm;
    new_ent.pc      = in_pc;
    new_ent.inst    = in_inst;
    new_ent.tag     = in_tag;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel.op   = ent[i].op;
        sel.vj   = ent[i].vj;
        sel.vk   = ent[i].vk;
        sel.imm  = ent[i].imm;
        sel.pc   = ent[i].pc;
        sel.inst = ent[i].inst;
        sel.tag  = ent[i].tag;
      end
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .alloc (alloc),
    .free  (free),
    .req   (req),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
      disp_q    <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          ent[i] <= '0;
        disp_q    <= '0;
        out_valid <= 1'b0;
        count     <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent[i].valid) begin
            {ent[i].qj_busy, ent[i].vj} <= wj[i];
            {ent[i].qk_busy, ent[i].vk} <= wk[i];
          end
          if (free[i])
            ent[i].valid <= 1'b0;
          if (alloc[i])
            ent[i] <= new_ent;
        end
        if (load) begin
          disp_q    <= sel;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        count <= count + CW'(issue) - CW'(load);
      end
    end
  end

  assign out_op   = disp_q.op;
  assign out_vj   = disp_q.vj;
  assign out_vk   = disp_q.vk;
  assign out_imm  = disp_q.imm;
  assign out_pc   = disp_q.pc;
  assign out_inst = disp_q.inst;
  assign out_tag  = disp_q.tag;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Self-checking bench for rs_multi_cdb: vector table plus directed
// multi-cycle sequences, dispatches checked against a scoreboard queue.
module tb_rs_multi_cdb;
  import rs_pkg::*;

  localparam int DEPTH = 16;
  localparam int NC    = 3;

  logic clk, rst_n, rdy, flush, in_valid;
  logic [OP_W-1:0] in_op;
  logic [XLEN-1:0] in_imm, in_pc, in_vj, in_vk;
  logic [31:0] in_inst;
  logic [TAG_W-1:0] in_tag, in_qj, in_qk;
  logic in_qj_busy, in_qk_busy, full;
  logic [$clog2(DEPTH):0] count;
  logic [NC-1:0] cdb_valid;
  logic [NC*TAG_W-1:0] cdb_tag;
  logic [NC*XLEN-1:0] cdb_data;
  logic out_valid, out_ready;
  logic [OP_W-1:0] out_op;
  logic [XLEN-1:0] out_vj, out_vk, out_imm, out_pc;
  logic [31:0] out_inst;
  logic [TAG_W-1:0] out_tag;

  rs_multi_cdb #(.DEPTH(DEPTH), .NUM_CDB(NC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_imm(in_imm),
    .in_pc(in_pc), .in_inst(in_inst), .in_tag(in_tag),
    .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
    .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_vj(out_vj), .out_vk(out_vk),
    .out_imm(out_imm), .out_pc(out_pc), .out_inst(out_inst),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0]    tag;
    logic                qjb;
    logic [TAG_W-1:0]    qj;
    logic [XLEN-1:0]     vj;
    logic                qkb;
    logic [TAG_W-1:0]    qk;
    logic [XLEN-1:0]     vk;
    logic [NC-1:0]       cv;
    logic [NC*TAG_W-1:0] ct;
    logic [NC*XLEN-1:0]  cd;
    logic [XLEN-1:0]     ej;
    logic [XLEN-1:0]     ek;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // dispatch monitor: every handshake must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rdy && !flush && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dispatch: got tag %0d required none",
                 out_tag);
      end else begin
        e = sb.pop_front();
        chk("disp_tag", 64'(out_tag), 64'(e.tag));
        chk("disp_vj", 64'(out_vj), 64'(e.vj));
        chk("disp_vk", 64'(out_vk), 64'(e.vk));
        chk("disp_imm", 64'(out_imm), 64'(e.tag) << 4);
        chk("disp_op", 64'(out_op), 64'(e.tag));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TAG_W-1:0] t,
                      input logic [XLEN-1:0] vj,
                      input logic [XLEN-1:0] vk);
    exp_t e;
    e.tag = t;
    e.vj = vj;
    e.vk = vk;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [TAG_W-1:0] t,
                       input logic qjb, input logic [TAG_W-1:0] qj,
                       input logic [XLEN-1:0] vj,
                       input logic qkb, input logic [TAG_W-1:0] qk,
                       input logic [XLEN-1:0] vk);
    if (full) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_while_full: got full=1 required 0");
    end
    in_valid = 1'b1;
    in_tag = t;
    in_op = OP_W'(t);
    in_imm = XLEN'(t) << 4;
    in_pc = 32'h1000 + (XLEN'(t) << 2);
    in_inst = 32'(t);
    in_qj_busy = qjb;
    in_qj = qj;
    in_vj = vj;
    in_qk_busy = qkb;
    in_qk = qk;
    in_vk = vk;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cdb(input int p, input logic [TAG_W-1:0] t,
                     input logic [XLEN-1:0] d);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W] = t;
    cdb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic cdb_clr;
    cdb_valid = '0;
    cdb_tag = '0;
    cdb_data = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{5'd4, 1'b1, 5'd9, 32'h0, 1'b0, 5'd0, 32'h1, 3'b001,
               {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'hAB}, 32'hAB, 32'h1};
    tbl[1] = '{5'd5, 1'b0, 5'd0, 32'h11, 1'b0, 5'd0, 32'h22, 3'b000,
               {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 32'h11, 32'h22};
    tbl[2] = '{5'd6, 1'b1, 5'd5, 32'h0, 1'b1, 5'd5, 32'h0, 3'b010,
               {5'd0, 5'd5, 5'd0}, {32'h0, 32'h55, 32'h0}, 32'h55, 32'h55};
    tbl[3] = '{5'd7, 1'b1, 5'd6, 32'h0, 1'b1, 5'd8, 32'h0, 3'b101,
               {5'd6, 5'd0, 5'd8}, {32'h66, 32'h0, 32'h88}, 32'h66, 32'h88};
    tbl[4] = '{5'd8, 1'b1, 5'd12, 32'h0, 1'b0, 5'd0, 32'h3, 3'b111,
               {5'd12, 5'd12, 5'd12}, {32'hA2, 32'hA1, 32'hA0},
               32'hA0, 32'h3};
    tbl[5] = '{5'd9, 1'b0, 5'd13, 32'h77, 1'b1, 5'd13, 32'h0, 3'b100,
               {5'd13, 5'd0, 5'd0}, {32'hD2, 32'h0, 32'h0},
               32'h77, 32'hD2};

    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_imm = '0; in_pc = '0; in_inst = '0; in_tag = '0;
    in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qj = '0; in_qk = '0;
    in_vj = '0; in_vk = '0; out_ready = 1'b0;
    cdb_clr();
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of traffic
    issue(5'd20, 1'b0, 5'd0, 32'h1, 1'b0, 5'd0, 32'h2);
    issue(5'd21, 1'b1, 5'd30, 32'h0, 1'b0, 5'd0, 32'h2);
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    chk("mid_pre_count", 64'(count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_full", 64'(full), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // wakeup on port 1 after issue
    out_ready = 1'b1;
    push(5'd3, 32'h10, 32'h5);
    issue(5'd3, 1'b1, 5'd7, 32'h0, 1'b0, 5'd0, 32'h5);
    chk("t2_count", 64'(count), 64'd1);
    cdb(1, 5'd7, 32'h10);
    tick();
    cdb_clr();
    chk("t2_not_early", 64'(out_valid), 64'd0);
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_vj", 64'(out_vj), 64'h10);
    chk("t2_vk", 64'(out_vk), 64'h5);
    drain("t2_drain", 5);

    // issue-time capture vectors
    for (int i = 0; i < 6; i++) begin
      cdb_valid = tbl[i].cv;
      cdb_tag = tbl[i].ct;
      cdb_data = tbl[i].cd;
      push(tbl[i].tag, tbl[i].ej, tbl[i].ek);
      issue(tbl[i].tag, tbl[i].qjb, tbl[i].qj, tbl[i].vj,
            tbl[i].qkb, tbl[i].qk, tbl[i].vk);
      cdb_clr();
    end
    drain("table_drain", 30);

    // both operands woken in the same cycle from ports 0 and 2
    push(5'd10, 32'h22, 32'h44);
    issue(5'd10, 1'b1, 5'd2, 32'h0, 1'b1, 5'd4, 32'h0);
    cdb(0, 5'd2, 32'h22);
    cdb(2, 5'd4, 32'h44);
    tick();
    cdb_clr();
    tick();
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_tag", 64'(out_tag), 64'd10);
    chk("t4_vj", 64'(out_vj), 64'h22);
    chk("t4_vk", 64'(out_vk), 64'h44);
    drain("t4_drain", 5);

    // age order with a stalled dispatch register
    out_ready = 1'b0;
    push(5'd15, 32'hF0, 32'hF1);
    issue(5'd15, 1'b0, 5'd0, 32'hF0, 1'b0, 5'd0, 32'hF1);
    push(5'd1, 32'h101, 32'h1);
    issue(5'd1, 1'b1, 5'd17, 32'h0, 1'b0, 5'd0, 32'h1);
    push(5'd2, 32'h102, 32'h2);
    issue(5'd2, 1'b1, 5'd18, 32'h0, 1'b0, 5'd0, 32'h2);
    push(5'd3, 32'h103, 32'h3);
    issue(5'd3, 1'b1, 5'd19, 32'h0, 1'b0, 5'd0, 32'h3);
    cdb(0, 5'd19, 32'h103);
    tick();
    cdb_clr();
    cdb(1, 5'd17, 32'h101);
    tick();
    cdb_clr();
    cdb(2, 5'd18, 32'h102);
    tick();
    cdb_clr();
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_tag", 64'(out_tag), 64'd15);
      chk("t5_hold_vj", 64'(out_vj), 64'hF0);
      chk("t5_hold_count", 64'(count), 64'd3);
      tick();
    end
    out_ready = 1'b1;
    drain("t5_drain", 20);

    // fill, single dispatch, flush
    out_ready = 1'b0;
    for (int t = 0; t < DEPTH + 1; t++) begin
      push(TAG_W'(t), XLEN'(t + 100), XLEN'(t + 200));
      issue(TAG_W'(t), 1'b0, 5'd0, XLEN'(t + 100),
            1'b0, 5'd0, XLEN'(t + 200));
    end
    chk("t6_full", 64'(full), 64'd1);
    chk("t6_count", 64'(count), 64'd16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_after_full", 64'(full), 64'd0);
    chk("t6_after_count", 64'(count), 64'd15);
    chk("t6_after_tag", 64'(out_tag), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_full", 64'(full), 64'd0);
    chk("flush_tag", 64'(out_tag), 64'd0);
    chk("flush_vj", 64'(out_vj), 64'd0);

    // rdy=0 ignores issue and cdb
    rdy = 1'b0;
    cdb(0, 5'd1, 32'h9);
    issue(5'd30, 1'b0, 5'd0, 32'h1, 1'b0, 5'd0, 32'h2);
    cdb_clr();
    rdy = 1'b1;
    chk("frz_count", 64'(count), 64'd0);
    tick();
    chk("frz_count2", 64'(count), 64'd0);
    chk("frz_valid", 64'(out_valid), 64'd0);

    out_ready = 1'b1;
    push(5'd22, 32'h5, 32'h6);
    issue(5'd22, 1'b0, 5'd0, 32'h5, 1'b0, 5'd0, 32'h6);
    drain("post_drain", 10);
    tick();
    chk("end_count", 64'(count), 64'd0);
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
